// File: rtl/add_sub_seq.sv
// ---------------------------------------------------------------------------
// add_sub_seq
//   Digit-serial two's-complement adder/subtractor. An operation is accepted
//   through a valid/ready handshake. The block then adds one DIGIT-wide slice
//   per cycle, LSB first, and presents the result with carry, signed-overflow
//   and zero flags. It holds them until the consumer takes them. If sat is
//   set, a signed overflow clamps the result to the most positive or most
//   negative value.
//
//   Parameters
//     WIDTH      operand/result width in bits (>= 2)
//     DIGIT      bits added per cycle; WIDTH must be a multiple of DIGIT
//     NUM_DIGITS derived digit count, leave at its default
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     in_valid   operands and mode are valid
//     in_ready   block can accept an operation (IDLE and not in reset)
//     a, b       operands
//     sub        0: a+b, 1: a-b
//     sat        clamp the result on signed overflow
//     out_valid  result and flags are valid
//     out_ready  consumer accepts the result
//     result     sum/difference (saturated if requested)
//     carry      carry out of the MSB; for subtraction 1 means no borrow
//     overflow   signed overflow of the unsaturated result
//     zero       final result equals zero
// ---------------------------------------------------------------------------
module add_sub_seq #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int NUM_DIGITS = WIDTH / DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_n;

  // Operation captured on the accept edge. d_q already holds B inverted for
  // subtraction, so the datapath is always a plain add with carry-in.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] d_q;
  logic             c_q;
  logic             sat_q;
  logic             a_msb_q;
  logic             d_msb_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             last_digit;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] d_dig;
  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] raw_full;
  logic             ovf_n;
  logic [WIDTH-1:0] final_val;

  assign in_ready   = (state == IDLE) & ~rst;
  assign out_valid  = (state == DONE) & ~rst;
  assign accept     = in_valid & in_ready;
  assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));

  // Digit datapath. raw_full is the current result register with the digit
  // being added this cycle merged in. On the last digit it is the complete
  // unsaturated sum, which is what the overflow rule needs.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment
    // so that no path leaves a value held, which would infer a latch.
    a_dig    = '0;
    d_dig    = '0;
    raw_full = result;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_dig = a_q[k*DIGIT +: DIGIT];
        d_dig = d_q[k*DIGIT +: DIGIT];
      end
    end
    digit_sum = {1'b0, a_dig} + {1'b0, d_dig} + {{DIGIT{1'b0}}, c_q};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        raw_full[k*DIGIT +: DIGIT] = digit_sum[DIGIT-1:0];
      end
    end
    // Two same-sign addends that give an opposite-sign sum have overflowed.
    ovf_n = (a_msb_q == d_msb_q) & (raw_full[WIDTH-1] != a_msb_q);
    if (sat_q && ovf_n) begin
      final_val = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_val = raw_full;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments, so every
    // register samples its pre-edge inputs regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept)     state_n = BUSY;
      BUSY:    if (last_digit) state_n = DONE;
      DONE:    if (out_ready)  state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  // Operand capture, digit iteration and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      d_q      <= '0;
      c_q      <= 1'b0;
      sat_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      d_msb_q  <= 1'b0;
      cnt_q    <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            d_q     <= b ^ {WIDTH{sub}};
            c_q     <= sub;
            sat_q   <= sat;
            a_msb_q <= a[WIDTH-1];
            d_msb_q <= b[WIDTH-1] ^ sub;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          c_q <= digit_sum[DIGIT];
          if (last_digit) begin
            cnt_q    <= '0;
            result   <= final_val;
            carry    <= digit_sum[DIGIT];
            overflow <= ovf_n;
            zero     <= (final_val == '0);
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            result <= raw_full;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/add_sub_seq.md
Name: add_sub_seq

Overview:
- Parametrised, digit-serial two's-complement adder/subtractor for the arithmetic datapath.
- Generalises the fixed-width ripple add/sub: a single mode bit inverts B and drives carry-in.
- Adds configurable width and digit size, a valid/ready handshake on both sides, and status flags (carry, signed overflow, zero).
- Adds an optional signed-saturation mode.

Parameters:
- WIDTH, 16: operand and result width in bits; must be at least 2.
- DIGIT, 4: bits processed per cycle; WIDTH must be an integer multiple of DIGIT.
- NUM_DIGITS, WIDTH/DIGIT: derived count of digit steps; not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B; 1 = A-B (B inverted, carry-in 1).
- sat  input  1  1 = clamp result on signed overflow.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference.
- carry  output  1  carry out of bit WIDTH-1; for subtraction 1 means no borrow.
- overflow  output  1  signed overflow of the unsaturated result.
- zero  output  1  final result (after saturation) equals 0.

Behaviour:
- States are IDLE, BUSY and DONE. Reset enters IDLE. During reset: out_valid=0, result=0, carry=0, overflow=0, zero=0, digit counter=0.
- in_ready = (state==IDLE) & ~rst. It is combinational and is 0 while rst is high.
- IDLE -> BUSY on the edge where in_valid & in_ready. On that edge, latch:
  - A;
  - D = B XOR {WIDTH{sub}};
  - running carry = sub;
  - sat;
  - sign bits A[WIDTH-1] and D[WIDTH-1].
  - The digit counter is cleared.
- BUSY, each cycle, processes digit k from LSB first:
  - {c, r_k} = A_k + D_k + c, a (DIGIT+1)-bit add.
  - r_k is written into result bits [k*DIGIT +: DIGIT]. Shift-register or indexed storage are both acceptable. Only the final value is observable.
  - The counter increments each cycle.
- After digit NUM_DIGITS-1 is processed, the state goes to DONE on the same edge. On that edge:
  - carry = final c;
  - overflow = (A_msb == D_msb) & (raw_msb != A_msb);
  - if sat & overflow, result = A_msb ? {1,0...0} : {0,1...1}; otherwise result = raw;
  - zero reflects the final result;
  - out_valid = 1.
- Latency: out_valid rises exactly NUM_DIGITS cycles after the accept edge. With DIGIT==WIDTH this is 1 cycle.
- result, carry, overflow and zero may change freely while out_valid=0. They hold stable from out_valid rise until the handshake.
- DONE holds out_valid=1 and all outputs stable until out_valid & out_ready. On that edge the state goes to IDLE and out_valid=0. Result and flags retain their last value.
- No same-cycle accept in DONE. A new operation is accepted at the earliest one cycle after the output handshake. Peak throughput is one op per NUM_DIGITS+2 cycles.
- in_valid is ignored in BUSY and DONE. Operand ports may change after the accept edge without affecting the operation in flight.
- Reset asserted mid-operation (BUSY or DONE) aborts it. Next state is IDLE, with all outputs at reset values and no partial result emitted.
- Wrap-around: when sat=0, the result is modulo 2^WIDTH and overflow is still reported.
- Flags are defined only while out_valid=1.

Test Plan:
- WIDTH=16, DIGIT=4: a=0x1234, b=0x0FED, sub=0, sat=0 -> result=0x2221, carry=0, overflow=0, zero=0; out_valid rises exactly 4 cycles after the accept edge.
- sub=1: a=0x0005, b=0x0005 -> result=0x0000, carry=1, zero=1, overflow=0. Then a=0x0003, b=0x0005 -> result=0xFFFE, carry=0 (borrow), overflow=0.
- Overflow and saturation:
  - a=0x7FFF, b=0x0001, sub=0: sat=0 -> 0x8000, overflow=1; sat=1 -> 0x7FFF, overflow=1.
  - a=0x8000, b=0x0001, sub=1, sat=1 -> 0x8000, overflow=1, carry=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, toggling in_valid and operands -> result and flags are stable, in_ready=0, no new op is accepted. Raise out_ready -> out_valid falls next edge; in_ready=1 the following cycle.
- Reset mid-op: assert rst for 1 cycle while digit 2 is in progress -> next cycle IDLE, out_valid=0, all flags 0, no output handshake occurs. A subsequent 0x0001+0x0001 gives 0x0002 with correct latency.
- Parameter sweep: (WIDTH=8, DIGIT=8) and (WIDTH=32, DIGIT=1) with random operands and modes against a reference model -> bit-exact result and flags; latency 1 and 32 cycles respectively.
